// File: rtl/seq_mul32.sv
// seq_mul32: multi-cycle 32x32 unsigned shift-and-add multiplier, 64-bit product.
// Wraps one 32-bit ripple adder (adc32); one iteration per clock, start/busy/done handshake.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier
// bits are all zero, aligning the partial product with a single shift.

module adc32 (
    input  logic [31:0] ai,
    input  logic [31:0] bi,
    input  logic        c0,
    output logic [31:0] s,
    output logic        co
);

    logic carry;

    // Bit-serial ripple carry chain, LSB first.
    always_comb begin
        carry = c0;
        s     = '0;
        for (int i = 0; i < 32; i++) begin
            s[i]  = ai[i] ^ bi[i] ^ carry;
            carry = (ai[i] & bi[i]) | (carry & (ai[i] ^ bi[i]));
        end
        co = carry;
    end

endmodule

module seq_mul32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] p
);

    // state | meaning
    // IDLE  | waiting for start; p holds last product
    // RUN   | one add-and-shift iteration per clock
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] mcand, mcand_nxt;
    logic [31:0] hi, hi_nxt;
    logic [31:0] lo, lo_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [63:0] p_nxt;
    logic        done_nxt;

    logic [31:0] add_b;
    logic [31:0] sum;
    logic        sum_co;
    logic [63:0] shifted;
    logic        early;

    assign add_b   = lo[0] ? mcand : 32'd0;
    assign shifted = {sum_co, sum, lo[31:1]};
    assign busy    = (state == RUN);

    adc32 u_adc32 (
        .ai (hi),
        .bi (add_b),
        .c0 (1'b0),
        .s  (sum),
        .co (sum_co)
    );

`ifdef MUL_EARLY_EXIT_EN
    // Remaining multiplier bits live in lo[31-cnt:0]; once they are zero the
    // rest of the iterations would only shift.
    assign early = ((lo & (32'hFFFF_FFFF >> cnt)) == 32'd0);
`else
    assign early = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            cnt   <= cnt_nxt;
            p     <= p_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state, iteration and finish logic.
    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        hi_nxt    = hi;
        lo_nxt    = lo;
        cnt_nxt   = cnt;
        p_nxt     = p;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_nxt = a;
                    hi_nxt    = '0;
                    lo_nxt    = b;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (early) begin
                    p_nxt     = {hi, lo} >> (6'd32 - {1'b0, cnt});
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    hi_nxt  = shifted[63:32];
                    lo_nxt  = shifted[31:0];
                    cnt_nxt = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        p_nxt     = shifted;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_mul32.sv
// tb_seq_mul32: scoreboard bench for seq_mul32. Driver pushes the exact product and
// expected latency on each accepted start; a monitor pops on every done pulse.
// Honors MUL_EARLY_EXIT_EN for the expected latency.

module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] p;

    seq_mul32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] prod;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_p = '0;

    function automatic int exp_lat(input logic [31:0] bb);
        int m;
        int lat;
        m = -1;
        for (int i = 0; i < 32; i++) if (bb[i]) m = i;
        lat = 32;
`ifdef MUL_EARLY_EXIT_EN
        if (m < 0) lat = 1;
        else lat = (m + 2 > 32) ? 32 : m + 2;
`endif
        return lat;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit hold, output int acc);
        int   n;
        bit   ok;
        logic bp;
        int   pre;
        exp_t e;
        n  = 0;
        ok = 1'b0;
        pre = 0;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        while (!ok && n < 200) begin
            bp  = busy;
            pre = cyc;
            @(posedge clk);
            if (!bp) ok = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        #1;
        if (!hold) start = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: start not accepted after %0d cycles", n);
            acc = 0;
        end else begin
            e.prod = {32'd0, x} * {32'd0, y};
            e.acc  = pre + 1;
            e.lat  = exp_lat(y);
            sb.push_back(e);
            acc = e.acc;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: %0d ops outstanding after %0d cycles", sb.size(), n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compare on every done pulse; check p hold and busy otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_done: got done=1 expected no pulse (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("product", p, e.prod);
                        check("latency", 64'(cyc - e.acc), 64'(e.lat));
                        check("busy_at_done", {63'd0, busy}, 64'd0);
                        last_p = e.prod;
                    end
                end else begin
                    check("p_hold", p, last_p);
                    if (sb.size() != 0) check("busy_run", {63'd0, busy}, 64'd1);
                end
            end
        end
    end

    logic [31:0] dir_a [8] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
                               32'hDEAD_BEEF, 32'h1234_5678, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] dir_b [8] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd1,
                               32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};

    initial begin
        int acc1;
        int acc2;
        logic [31:0] x;
        logic [31:0] y;

        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_p", p, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(dir_a[i], dir_b[i], 1'b0, acc1);
            wait_idle();
        end

        // Start while busy must be ignored.
        issue(32'd1000, 32'd2000, 1'b0, acc1);
        repeat (10) @(posedge clk);
        #1;
        a = 32'hCAFE_F00D;
        b = 32'h0BAD_0BAD;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-run.
        issue(32'hABCD_1234, 32'h8765_4321, 1'b0, acc1);
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_p", p, 64'd0);
        sb.delete();
        last_p = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd7, 32'd9, 1'b0, acc1);
        wait_idle();

        // Start held high across two operations.
        issue(32'd6, 32'd7, 1'b1, acc1);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, acc2);
        check("b2b_spacing", 64'(acc2 - acc1), 64'(exp_lat(32'd7) + 1));
        wait_idle();

        // Randomized operands, multiplier widths spread to exercise early exit.
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            issue(x, y, 1'b0, acc1);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
